// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush/jump bubbles and saturating bubble counters
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        id_wb,
  input  logic [2:0]        id_m,
  input  logic [4:0]        id_ex,
  input  logic              id_j,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              flush,
  output logic [1:0]        ex_wb,
  output logic [2:0]        ex_m,
  output logic [4:0]        ex_ex,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic ex_load, uses_rt, hazard, bubble, stall_inc, flush_inc;
  assign ex_load    = ex_wb[0] & ~ex_wb[1];
  assign uses_rt    = ~id_ex[4] | id_m[1];
  assign hazard     = ex_load & (ex_rt != '0) & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
  assign bubble     = flush | hazard | id_j;
  assign stall_inc  = hazard & ~flush;
  assign flush_inc  = flush | (~hazard & id_j);
  assign pc_write   = ~stall_inc;
  assign ifid_write = ~stall_inc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_wb     <= '0;
      ex_m      <= '0;
      ex_ex     <= '0;
      ex_pc4    <= '0;
      ex_rd1    <= '0;
      ex_rd2    <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_wb     <= bubble ? '0 : id_wb;
      ex_m      <= bubble ? '0 : id_m;
      ex_ex     <= bubble ? '0 : id_ex;
      ex_pc4    <= bubble ? '0 : id_pc4;
      ex_rd1    <= bubble ? '0 : id_rd1;
      ex_rd2    <= bubble ? '0 : id_rd2;
      ex_imm    <= bubble ? '0 : id_imm;
      ex_rs     <= bubble ? '0 : id_rs;
      ex_rt     <= bubble ? '0 : id_rt;
      ex_rd     <= bubble ? '0 : id_rd;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end
endmodule
